// File: rtl/ibuffer_unpack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ibuffer_unpack_pkg                                               |
// | Shared types, widths and segment selection for ibuffer_unpack.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ibuffer_unpack_pkg;

  localparam int SEG_W  = 16;
  localparam int WORD_W = 64;
  localparam int SEGS   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Index 0 is the most significant segment, matching the writer's packing order.
  function automatic logic [SEG_W-1:0] seg_sel(input logic [WORD_W-1:0] word,
                                               input logic [1:0]        idx);
    logic [SEG_W-1:0] seg;
    case (idx)
      2'd0:    seg = word[63:48];
      2'd1:    seg = word[47:32];
      2'd2:    seg = word[31:16];
      default: seg = word[15:0];
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibuffer_unpack_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_fifo2                                                       |
// | Two-entry 64-bit word FIFO with simultaneous push and pop.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module word_fifo2
  import ibuffer_unpack_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] r_mem [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = pop & (r_count != 2'd0);
  assign w_push = push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ibuffer_unpack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ibuffer_unpack                                                   |
// | Fetches a run of SRAM words and streams them as 16-bit segments. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ibuffer_unpack
  import ibuffer_unpack_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [AW-1:0]     BASE,
  input  logic [AW:0]       LEN,
  output logic              RREQ,
  output logic [AW-1:0]     RADDR,
  input  logic              RVALID,
  input  logic [WORD_W-1:0] RDATA,
  input  logic              EN,
  output logic [SEG_W-1:0]  OData,
  output logic              OValid,
  output logic              Busy,
  output logic              Done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_addr;
  logic [AW:0]       r_issue_left;
  logic [AW:0]       r_consume_left;
  logic [1:0]        r_seg_cnt;
  logic              r_pending;
  logic              r_done;
  logic [WORD_W-1:0] w_head;
  logic [1:0]        w_count;
  logic [2:0]        w_inflight;
  logic              w_push;
  logic              w_consume;
  logic              w_pop;
  logic              w_last;
  logic              w_start_idle;

  // Read latency is exactly one cycle, so the previous cycle's request is the only one in flight.
  assign w_push       = RVALID & r_pending;
  assign w_inflight   = {1'b0, w_count} + {2'b00, r_pending};
  assign w_consume    = EN & OValid;
  assign w_pop        = w_consume & (r_seg_cnt == 2'd3);
  assign w_last       = w_pop & (r_consume_left == (AW+1)'(1));
  assign w_start_idle = START & (r_state == IDLE);

  assign RREQ   = (r_state == FETCH) & (w_inflight < 3'd2) & (r_issue_left != '0);
  assign RADDR  = r_addr;
  assign OValid = (w_count != 2'd0);
  assign OData  = seg_sel(w_head, r_seg_cnt);
  assign Busy   = (r_state != IDLE);
  assign Done   = r_done;

  word_fifo2 u_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (w_push),
    .pop   (w_pop),
    .din   (RDATA),
    .head  (w_head),
    .count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (START && (LEN != '0))                     w_state_nxt = FETCH;
      FETCH:   if (RREQ && (r_issue_left == (AW+1)'(1)))     w_state_nxt = DRAIN;
      DRAIN:   if (w_last)                                   w_state_nxt = IDLE;
      default:                                               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_issue_left   <= '0;
      r_consume_left <= '0;
      r_seg_cnt      <= 2'd0;
      r_pending      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= RREQ;
      r_done    <= (w_start_idle & (LEN == '0)) | w_last;
      if (w_start_idle) begin
        r_addr         <= BASE;
        r_issue_left   <= LEN;
        r_consume_left <= LEN;
      end else begin
        if (RREQ) begin
          r_addr       <= r_addr + AW'(1);
          r_issue_left <= r_issue_left - (AW+1)'(1);
        end
        if (w_pop) begin
          r_consume_left <= r_consume_left - (AW+1)'(1);
        end
      end
      if (w_consume) begin
        r_seg_cnt <= r_seg_cnt + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibuffer_unpack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ibuffer_unpack                                                |
// | Self-checking bench: SRAM responder, run-level model, directed.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ibuffer_unpack;

  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          START = 1'b0;
  logic [AW-1:0] BASE = '0;
  logic [AW:0]   LEN = '0;
  logic          RREQ;
  logic [AW-1:0] RADDR;
  logic          RVALID = 1'b0;
  logic [63:0]   RDATA = '0;
  logic          EN = 1'b0;
  logic [15:0]   OData;
  logic          OValid;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] mem [256];
  logic        inj = 1'b0;

  // Run-level model state, owned by the compare process.
  int          addr_q[$];
  logic [15:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_segs = 0;
  int          m_words = 0;
  logic        nd;
  logic        bnow;
  int          ma;
  logic [63:0] mw;

  ibuffer_unpack #(.AW(AW)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .START  (START),
    .BASE   (BASE),
    .LEN    (LEN),
    .RREQ   (RREQ),
    .RADDR  (RADDR),
    .RVALID (RVALID),
    .RDATA  (RDATA),
    .EN     (EN),
    .OData  (OData),
    .OValid (OValid),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: answers each request one cycle later; inj forces a stray response.
  initial begin
    logic          rq;
    logic [AW-1:0] ad;
    forever begin
      @(negedge CLK);
      rq = RREQ;
      ad = RADDR;
      @(posedge CLK);
      #1;
      RVALID = rq | inj;
      RDATA  = inj ? 64'hDEAD_BEEF_0BAD_F00D : mem[ad];
    end
  end

  // Compare process: the model expands each accepted run into addresses and segments.
  always @(negedge CLK) begin
    if (!RSTN) begin
      addr_q.delete();
      exp_q.delete();
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_segs  = 0;
      m_words = 0;
    end else begin
      check("busy", Busy, m_busy);
      check("done", Done, m_done);
      if (RREQ) begin
        if (addr_q.size() == 0) check("unexpected_rreq", RREQ, 1'b0);
        else                    check("raddr", RADDR, addr_q.pop_front());
        m_words++;
        check("credit_le2", (m_words - m_segs / 4) <= 2, 1'b1);
      end
      nd   = 1'b0;
      bnow = m_busy;
      if (OValid && EN) begin
        if (exp_q.size() == 0) check("unexpected_seg", OValid, 1'b0);
        else                   check("odata", OData, exp_q.pop_front());
        m_segs++;
        if (exp_q.size() == 0 && bnow) begin
          m_busy = 1'b0;
          nd     = 1'b1;
        end
      end
      if (START && !bnow) begin
        if (LEN == '0) begin
          nd = 1'b1;
        end else begin
          m_busy = 1'b1;
          for (int i = 0; i < int'(LEN); i++) begin
            ma = (int'(BASE) + i) % 256;
            mw = mem[ma];
            addr_q.push_back(ma);
            for (int k = 0; k < 4; k++) exp_q.push_back(16'(mw >> (48 - 16 * k)));
          end
        end
      end
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [AW:0] l, output int t);
    t     = cyc;
    BASE  = b;
    LEN   = l;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("run_finished_in_budget", n < budget, 1'b1);
    tick();
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rreq"},   RREQ,   1'b0);
    check({tag, "_raddr"},  RADDR,  '0);
    check({tag, "_odata"},  OData,  '0);
    check({tag, "_ovalid"}, OValid, 1'b0);
    check({tag, "_busy"},   Busy,   1'b0);
    check({tag, "_done"},   Done,   1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t;
    int            n;
    int            s0;
    int            nreq;
    int            first;
    int            last;
    int            done_c;
    int            rq_c;
    logic [15:0]   segs [4];
    logic [AW-1:0] ads [2];
    logic [15:0]   lit [4];
    logic [7:0]    bb;

    for (int i = 0; i < 256; i++) begin
      bb     = 8'(i);
      mem[i] = {bb, 8'hA0, bb, 8'hB1, bb, 8'hC2, bb, 8'hD3};
    end
    mem[16'h10] = 64'h1111_2222_3333_4444;
    lit[0] = 16'h1111; lit[1] = 16'h2222; lit[2] = 16'h3333; lit[3] = 16'h4444;

    // Reset values, then quiet idle.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_zero_outputs("reset");
    #1 RSTN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_rreq", RREQ, 1'b0);
    end
    tick();

    // Single word, EN held high.
    EN = 1'b1;
    go(8'h10, 9'd1, t);
    nreq = 0; n = 0; first = -1; last = -1; done_c = -1; rq_c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (RREQ) begin
        if (nreq == 0) begin ads[0] = RADDR; rq_c = cyc; end
        nreq++;
      end
      if (OValid && EN) begin
        if (n < 4) segs[n] = OData;
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
      if (Done) done_c = cyc;
    end
    check("single_nreq", nreq, 1);
    check("single_raddr", ads[0], 8'h10);
    check("single_nsegs", n, 4);
    for (int k = 0; k < 4; k++) check("single_seg_literal", segs[k], lit[k]);
    check("single_first_rreq_latency", rq_c - t, 1);
    check("single_first_ovalid_latency", first - t, 3);
    check("single_consecutive", last - first, 3);
    check("single_done_cycle", done_c - last, 1);
    tick();

    // Streaming: 8 words, 32 segments without bubbles.
    go(8'h40, 9'd8, t);
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (OValid) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    check("stream_nvalid", n, 32);
    check("stream_no_bubbles", last - first, 31);
    tick();

    // Stalls: random EN, including EN while nothing is valid.
    s0 = m_segs;
    go(8'h80, 9'd3, t);
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 300) begin
      EN = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("stall_finished_in_budget", n < 300, 1'b1);
    EN = 1'b0;
    tick();
    tick();
    check("stall_segment_count", m_segs - s0, 12);

    // LEN=0: Done at t+1 and no requests.
    go(8'h05, 9'd0, t);
    @(negedge CLK);
    check("len0_done_pulse", Done, 1'b1);
    check("len0_busy", Busy, 1'b0);
    check("len0_no_rreq", RREQ, 1'b0);
    @(negedge CLK);
    check("len0_done_single", Done, 1'b0);
    check("len0_no_rreq_later", RREQ, 1'b0);
    tick();

    // Address wrap plus a START while busy that must be ignored.
    EN = 1'b1;
    go(8'hFF, 9'd2, t);
    nreq = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (RREQ) begin
        if (nreq < 2) ads[nreq] = RADDR;
        nreq++;
      end
      @(posedge CLK);
      #1;
      if (i == 1) begin
        START = 1'b1; BASE = 8'h33; LEN = 9'd5;
      end else begin
        START = 1'b0;
      end
    end
    check("wrap_nreq", nreq, 2);
    check("wrap_raddr0", ads[0], 8'hFF);
    check("wrap_raddr1", ads[1], 8'h00);
    check("wrap_idle_after", Busy, 1'b0);

    // Reset in the middle of a run.
    s0 = m_segs;
    go(8'h60, 9'd2, t);
    n = 0;
    while ((m_segs - s0) < 5 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("midrun_reached_5", n < 100, 1'b1);
    #1 RSTN = 1'b0;
    #2 check_zero_outputs("midrun_reset");
    tick();
    tick();
    @(negedge CLK);
    #1;
    RSTN = 1'b1;
    inj  = 1'b1;
    @(negedge CLK);
    inj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("late_rvalid_discarded", OValid, 1'b0);
    end
    tick();
    s0 = m_segs;
    go(8'h20, 9'd1, t);
    wait_run(60);
    check("post_reset_segments", m_segs - s0, 4);

    EN = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
